countdown_timer: RTL and testbench

//  Loadable down-counter: the count-down companion to the existing 4-bit up-counter.

---
 rtl/timer_defs.sv | 13 +
 rtl/countdown_timer.sv | 115 +++++++++++
 tb/tb_countdown_timer.sv | 190 +++++++++++++++++++
 3 files changed

// File: rtl/timer_defs.sv
// Shared definitions for the countdown timer: FSM state encodings and default width.
package timer_defs;

  localparam int TIMER_WIDTH = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/countdown_timer.sv
// Loadable down-counter with terminal-count pulse, hold/pause, abort and optional auto-reload.
// No valid/ready handshake: Start is a single-cycle request, and every registered output is valid every cycle.
module countdown_timer
  import timer_defs::*;
#(
  parameter int WIDTH = TIMER_WIDTH
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] Load,
  input  logic             Hold,
  input  logic             Abort,
  input  logic             Reload_en,
  output logic [WIDTH-1:0] Count,
  output logic             Busy,
  output logic             Tc,
  output logic             Done,
  output logic [1:0]       dbg_state
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             tc_q, tc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic idle_like;
  logic active;
  logic start_ok;
  logic step;
  logic terminal;

  // Hold outranks Start, so a held timer in IDLE/DONE ignores a start request.
  assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign active    = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign start_ok  = idle_like && Start && !Hold && !Abort;
  assign step      = active && !Hold && !Abort;
  assign terminal  = (count_q <= WIDTH'(1));

  // FSM: next state and the status flags decoded from it
  always_comb begin
    state_d = state_q;
    if (Abort) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start_ok) state_d = (Load != '0) ? ST_RUN : ST_DONE;
        end
        ST_RUN, ST_PAUSE: begin
          if (Hold)                        state_d = ST_PAUSE;
          else if (terminal && !Reload_en) state_d = ST_DONE;
          else                             state_d = ST_RUN;
        end
        default: state_d = ST_IDLE;
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Datapath: count, reload register and the terminal-count pulse
  always_comb begin
    count_d  = count_q;
    reload_d = reload_q;
    tc_d     = 1'b0;
    if (Abort) begin
      count_d = '0;
    end else if (start_ok) begin
      count_d = Load;
      if (Load != '0) reload_d = Load;
      else            tc_d     = 1'b1;
    end else if (step) begin
      if (terminal) begin
        tc_d    = 1'b1;
        count_d = Reload_en ? reload_q : '0;
      end else begin
        count_d = count_q - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      count_q  <= '0;
      reload_q <= '0;
      tc_q     <= 1'b0;
    end else begin
      count_q  <= count_d;
      reload_q <= reload_d;
      tc_q     <= tc_d;
    end
  end

  assign Count     = count_q;
  assign Busy      = busy_q;
  assign Tc        = tc_q;
  assign Done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios plus random traffic, checked through an expected-output queue.
module tb_countdown_timer;

  localparam int W = 4;
  localparam int PW = 2 + W + 3;

  logic         Clk;
  logic         Reset_n;
  logic         Start;
  logic [W-1:0] Load;
  logic         Hold;
  logic         Abort;
  logic         Reload_en;
  logic [W-1:0] Count;
  logic         Busy;
  logic         Tc;
  logic         Done;
  logic [1:0]   dbg_state;

  int total = 0;
  int bad   = 0;

  logic [PW-1:0] exp_q[$];

  // Reference model kept as plain integers
  int m_mode;      // 0 idle, 1 run, 2 pause, 3 done
  int m_count;
  int m_reload;
  int m_tc;

  countdown_timer #(.WIDTH(W)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .Start(Start), .Load(Load), .Hold(Hold),
    .Abort(Abort), .Reload_en(Reload_en), .Count(Count), .Busy(Busy),
    .Tc(Tc), .Done(Done), .dbg_state(dbg_state)
  );

  // clock / reset
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_count = 0; m_reload = 0; m_tc = 0;
  endtask

  task automatic model_step(input bit s, input int l, input bit h, input bit a, input bit r);
    m_tc = 0;
    if (a) begin
      m_mode = 0; m_count = 0;
    end else if (m_mode == 1 || m_mode == 2) begin
      if (h) m_mode = 2;
      else begin
        m_mode = 1;
        if (m_count > 1) m_count = m_count - 1;
        else begin
          m_tc = 1;
          if (r) m_count = m_reload;
          else begin m_count = 0; m_mode = 3; end
        end
      end
    end else if (!h && s) begin
      m_count = l;
      if (l != 0) begin m_mode = 1; m_reload = l; end
      else begin m_mode = 3; m_tc = 1; end
    end
  endtask

  function automatic logic [PW-1:0] model_pack();
    logic [1:0]   st;
    logic [W-1:0] c;
    logic         b, t, d;
    st = 2'(m_mode);
    c  = W'(m_count);
    b  = (m_mode == 1 || m_mode == 2);
    t  = (m_tc != 0);
    d  = (m_mode == 3);
    return {st, c, b, t, d};
  endfunction

  // driver: one clock of stimulus, expected post-edge outputs queued
  task automatic cyc(input bit s, input int l, input bit h, input bit a, input bit r);
    @(negedge Clk);
    #1;
    Start = s; Load = W'(l); Hold = h; Abort = a; Reload_en = r;
    model_step(s, l, h, a, r);
    exp_q.push_back(model_pack());
  endtask

  task automatic idle_cycles(input int n, input bit r);
    for (int i = 0; i < n; i++) cyc(1'b0, 0, 1'b0, 1'b0, r);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_count"}, int'(Count), 0);
    chk({tag, "_busy"},  int'(Busy), 0);
    chk({tag, "_tc"},    int'(Tc), 0);
    chk({tag, "_done"},  int'(Done), 0);
    chk({tag, "_state"}, int'(dbg_state), 0);
  endtask

  // monitor / scoreboard
  initial begin
    logic [PW-1:0] e;
    forever begin
      @(negedge Clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("state", int'(dbg_state), int'(e[PW-1 -: 2]));
        chk("count", int'(Count),     int'(e[W+2:3]));
        chk("busy",  int'(Busy),      int'(e[2]));
        chk("tc",    int'(Tc),        int'(e[1]));
        chk("done",  int'(Done),      int'(e[0]));
      end
    end
  end

  // stimulus
  initial begin
    Reset_n = 1'b0; Start = 1'b0; Load = '0; Hold = 1'b0; Abort = 1'b0; Reload_en = 1'b0;
    model_reset();
    #2;
    check_reset_values("por");
    #10;
    Reset_n = 1'b1;

    // Load=5 single shot
    cyc(1'b1, 5, 1'b0, 1'b0, 1'b0);
    idle_cycles(7, 1'b0);

    // Load=3 auto-reload
    cyc(1'b1, 3, 1'b0, 1'b0, 1'b1);
    idle_cycles(10, 1'b1);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b1);

    // Load=9, hold four cycles at count 6
    cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
    idle_cycles(3, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 0, 1'b1, 1'b0, 1'b0);
    idle_cycles(9, 1'b0);

    // abort together with start, start ignored while running, abort at count 1
    cyc(1'b1, 4, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 4, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 12, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);
    cyc(1'b0, 0, 1'b0, 1'b1, 1'b0);
    idle_cycles(2, 1'b0);

    // Load=0 goes straight to done, then Load=15 from done
    cyc(1'b1, 0, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);
    cyc(1'b1, 15, 1'b0, 1'b0, 1'b0);
    idle_cycles(17, 1'b0);

    // asynchronous reset in the middle of a run at count 7
    cyc(1'b1, 9, 1'b0, 1'b0, 1'b0);
    idle_cycles(2, 1'b0);
    @(negedge Clk);
    #2;
    Reset_n = 1'b0;
    #1;
    check_reset_values("midrst");
    model_reset();
    #1;
    Reset_n = 1'b1;

    // random traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 9) < 3), int'($urandom_range(0, 15)),
          ($urandom_range(0, 19) < 3), ($urandom_range(0, 29) == 0),
          ($urandom_range(0, 1) == 1));
    end
    idle_cycles(20, 1'b0);

    repeat (3) @(negedge Clk);
    #1;
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
